// File: rtl/result_mem_readout_ctrl_if.sv
// Result-word stream from the readout controller: one word per valid/ready
// handshake, tagged with its frame and coefficient indices.
interface result_mem_readout_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_W    = 7,
  parameter int COEF_W     = 7
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [FRAME_W-1:0]    out_frame;
  logic [COEF_W-1:0]     out_coef;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_frame, out_coef, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_frame, out_coef, out_last,
    output out_ready
  );
endinterface

// File: rtl/result_mem_readout_ctrl.sv
// Walks frames 2..frame_num-3 and coefficients 0..2*cep_num+1 of the result
// memory after the MFCC core finishes, streaming each word out with its tags.
//
// state | meaning
// IDLE  | waiting for start; core owns the memory address
// CHECK | limits latched; decide between empty range and readout
// ISSUE | mem_cen low for one cycle at {frame_cnt, coef_cnt}
// WAIT  | down-count the read latency, then capture mem_rdata
// HOLD  | word presented on the stream until accepted
// FIN   | done pulse; address mux returned to the core
module result_mem_readout_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_W    = 7,
  parameter int COEF_W     = 7,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [FRAME_W-1:0]        frame_num,
  input  logic [6:0]                cep_num,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_addr_sel,
  output logic                      mem_cen,
  output logic                      mem_wen,
  output logic [FRAME_W+COEF_W-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  result_mem_readout_ctrl_if.master out_if
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] frame_q;
  logic [5:0]         cep_q;
  logic [FRAME_W-1:0] frame_cnt;
  logic [COEF_W-1:0]  coef_cnt;
  logic [1:0]         wait_cnt;

  logic [FRAME_W:0]   last_frame;
  logic [COEF_W-1:0]  coef_last;
  logic               coef_wrap;
  logic               is_last;
  logic [FRAME_W-1:0] next_frame;
  logic [COEF_W-1:0]  next_coef;
  logic               unused_cep_msb;

  // One extra bit keeps frame_num-3 from wrapping into a valid frame index.
  assign last_frame     = {1'b0, frame_q} - (FRAME_W+1)'(3);
  assign coef_last      = COEF_W'({cep_q, 1'b1});
  assign coef_wrap      = (coef_cnt == coef_last);
  assign is_last        = ({1'b0, frame_cnt} == last_frame) && coef_wrap;
  assign next_coef      = coef_wrap ? '0 : coef_cnt + COEF_W'(1);
  assign next_frame     = coef_wrap ? frame_cnt + FRAME_W'(1) : frame_cnt;
  assign mem_wen        = 1'b1;
  assign unused_cep_msb = cep_num[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_addr_sel     <= 1'b1;
      mem_cen          <= 1'b1;
      mem_addr         <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_frame <= '0;
      out_if.out_coef  <= '0;
      out_if.out_last  <= 1'b0;
      frame_q          <= '0;
      cep_q            <= '0;
      frame_cnt        <= '0;
      coef_cnt         <= '0;
      wait_cnt         <= '0;
    end else if (abort && state != IDLE) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_addr_sel     <= 1'b1;
      mem_cen          <= 1'b1;
      out_if.out_valid <= 1'b0;
      out_if.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frame_q   <= frame_num;
            cep_q     <= cep_num[5:0];
            frame_cnt <= FRAME_W'(2);
            coef_cnt  <= '0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (frame_q < FRAME_W'(5)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            mem_addr_sel <= 1'b0;
            mem_cen      <= 1'b0;
            mem_addr     <= {frame_cnt, coef_cnt};
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          mem_cen  <= 1'b1;
          wait_cnt <= 2'(RD_LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            out_if.out_data  <= mem_rdata;
            out_if.out_frame <= frame_cnt;
            out_if.out_coef  <= coef_cnt;
            out_if.out_last  <= is_last;
            out_if.out_valid <= 1'b1;
            state            <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        HOLD: begin
          if (out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
            if (out_if.out_last) begin
              out_if.out_last <= 1'b0;
              done            <= 1'b1;
              busy            <= 1'b0;
              mem_addr_sel    <= 1'b1;
              state           <= FIN;
            end else begin
              frame_cnt <= next_frame;
              coef_cnt  <= next_coef;
              mem_addr  <= {next_frame, next_coef};
              mem_cen   <= 1'b0;
              state     <= ISSUE;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_mem_readout_ctrl.sv
// Directed bench: DUT0 with 1-cycle read latency, DUT1 with 3-cycle latency,
// each fed by a memory model whose word is a fixed function of its address.
module tb_result_mem_readout_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_pulse;
  logic        abort;
  logic        ready;
  logic        sel;
  logic [6:0]  frame_num;
  logic [6:0]  cep_num;

  logic        start0, start1;
  logic        busy0, done0, sel0, cen0, wen0;
  logic        busy1, done1, sel1, cen1, wen1;
  logic [13:0] addr0, addr1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  result_mem_readout_ctrl_if #(.DATA_WIDTH(32), .FRAME_W(7), .COEF_W(7)) if0 ();
  result_mem_readout_ctrl_if #(.DATA_WIDTH(32), .FRAME_W(7), .COEF_W(7)) if1 ();

  assign start0        = start_pulse & ~sel;
  assign start1        = start_pulse & sel;
  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  result_mem_readout_ctrl #(.DATA_WIDTH(32), .FRAME_W(7), .COEF_W(7), .RD_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .frame_num(frame_num), .cep_num(cep_num), .busy(busy0), .done(done0),
    .mem_addr_sel(sel0), .mem_cen(cen0), .mem_wen(wen0), .mem_addr(addr0),
    .mem_rdata(rdata0), .out_if(if0)
  );

  result_mem_readout_ctrl #(.DATA_WIDTH(32), .FRAME_W(7), .COEF_W(7), .RD_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .frame_num(frame_num), .cep_num(cep_num), .busy(busy1), .done(done1),
    .mem_addr_sel(sel1), .mem_cen(cen1), .mem_wen(wen1), .mem_addr(addr1),
    .mem_rdata(rdata1), .out_if(if1)
  );

  function automatic logic [31:0] mem_val(input logic [13:0] a);
    return {a, 4'hA, ~a};
  endfunction

  // Read data is only valid for exactly one cycle, RD_LATENCY after the enable.
  always @(posedge clk) begin
    pipe0    <= !cen0 ? mem_val(addr0) : 32'hDEAD_BEEF;
    pipe1[0] <= !cen1 ? mem_val(addr1) : 32'hDEAD_BEEF;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rdata0 = pipe0;
  assign rdata1 = pipe1[2];

  logic        m_valid, m_cen, m_done, m_last;
  logic [31:0] m_data;
  logic [6:0]  m_frame, m_coef;
  logic [13:0] m_addr;
  assign m_valid = sel ? if1.out_valid : if0.out_valid;
  assign m_last  = sel ? if1.out_last  : if0.out_last;
  assign m_data  = sel ? if1.out_data  : if0.out_data;
  assign m_frame = sel ? if1.out_frame : if0.out_frame;
  assign m_coef  = sel ? if1.out_coef  : if0.out_coef;
  assign m_cen   = sel ? cen1  : cen0;
  assign m_done  = sel ? done1 : done0;
  assign m_addr  = sel ? addr1 : addr0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  int cyc = 0;
  int hs_cnt, cen_cnt, valid_cnt, done_cnt, seq_err, stall_err;
  int start_cyc, first_valid_cyc, done_cyc, first_hs_cyc, last_hs_cyc;
  int exp_frame, exp_coef, exp_last_frame, exp_coef_last;
  bit start_seen, first_seen, stall_prev, last_flag;
  logic [13:0] first_addr, last_addr, first_cen_addr;
  logic [31:0] p_data;
  logic [6:0]  p_frame, p_coef;

  task automatic clr_mon(input int fn, input int cn);
    hs_cnt = 0; cen_cnt = 0; valid_cnt = 0; done_cnt = 0; seq_err = 0; stall_err = 0;
    start_cyc = 0; first_valid_cyc = 0; done_cyc = 0; first_hs_cyc = 0; last_hs_cyc = 0;
    start_seen = 0; first_seen = 0; stall_prev = 0; last_flag = 0;
    first_addr = '0; last_addr = '0; first_cen_addr = '0;
    exp_frame = 2; exp_coef = 0;
    exp_last_frame = fn - 3;
    exp_coef_last  = (cn % 64) * 2 + 1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (start_pulse && !start_seen) begin start_seen = 1; start_cyc = cyc; end
    if (m_valid && !first_seen) begin first_seen = 1; first_valid_cyc = cyc; end
    if (!m_cen) begin
      if (cen_cnt == 0) first_cen_addr = m_addr;
      cen_cnt++;
    end
    if (m_valid) valid_cnt++;
    if (m_done) begin done_cnt++; done_cyc = cyc; end
    if (stall_prev && !(m_valid && m_data == p_data && m_frame == p_frame && m_coef == p_coef))
      stall_err++;
    stall_prev = m_valid && !ready;
    p_data = m_data; p_frame = m_frame; p_coef = m_coef;
    if (m_valid && ready) begin
      if (hs_cnt == 0) begin first_addr = {m_frame, m_coef}; first_hs_cyc = cyc; end
      last_addr = {m_frame, m_coef}; last_flag = m_last; last_hs_cyc = cyc;
      if (int'(m_frame) != exp_frame || int'(m_coef) != exp_coef ||
          m_data != mem_val({m_frame, m_coef}) ||
          m_last != (exp_frame == exp_last_frame && exp_coef == exp_coef_last))
        seq_err++;
      hs_cnt++;
      if (exp_coef == exp_coef_last) begin exp_coef = 0; exp_frame++; end
      else exp_coef++;
    end
  end

  task automatic run_readout(input bit which, input int fn, input int cn, input bit rand_ready,
                             input bit poke_busy, output bit got_done);
    sel = which;
    clr_mon(fn, cn);
    frame_num = 7'(fn);
    cep_num   = 7'(cn);
    ready = 1'b1;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    got_done = 0;
    for (int i = 0; i < 20000 && !got_done; i++) begin
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_busy && i == 200) begin
        start_pulse = 1'b1; frame_num = 7'd10; cep_num = 7'd5;
      end else begin
        start_pulse = 1'b0;
      end
      @(negedge clk);
      got_done = (done_cnt != 0);
    end
    start_pulse = 1'b0;
    ready = 1'b1;
  endtask

  bit got;

  initial begin
    rst_n = 1'b0; start_pulse = 1'b0; abort = 1'b0; ready = 1'b0; sel = 1'b0;
    frame_num = '0; cep_num = '0;
    clr_mon(24, 31);
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy0, 0);
    check_val("rst_done", done0, 0);
    check_val("rst_addr_sel", sel0, 1);
    check_val("rst_cen", cen0, 1);
    check_val("rst_wen", wen0, 1);
    check_val("rst_addr", addr0, 0);
    check_val("rst_valid", if0.out_valid, 0);
    check_val("rst_data", if0.out_data, 0);
    check_val("rst_last", if0.out_last, 0);
    check_val("rst_addr_sel_dut1", sel1, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal run with a second start and changed limits partway through.
    run_readout(0, 24, 31, 0, 1, got);
    check_val("nom_done_seen", got, 1);
    check_val("nom_words", hs_cnt, 1280);
    check_val("nom_seq", seq_err, 0);
    check_val("nom_cen_pulses", cen_cnt, 1280);
    check_val("nom_first_cen_addr", first_cen_addr, 14'h100);
    check_val("nom_first_addr", first_addr, 14'h100);
    check_val("nom_last_addr", last_addr, 14'hABF);
    check_val("nom_last_flag", last_flag, 1);
    check_val("nom_done_after_last", done_cyc - last_hs_cyc, 1);
    check_val("nom_done_count", done_cnt, 1);
    check_val("nom_latency", first_valid_cyc - start_cyc, 4);
    check_val("nom_throughput", last_hs_cyc - first_hs_cyc, 3 * 1279);
    check_val("nom_end_addr_sel", sel0, 1);
    check_val("nom_end_busy", busy0, 0);

    // Random backpressure.
    run_readout(0, 24, 31, 1, 0, got);
    check_val("bp_done_seen", got, 1);
    check_val("bp_words", hs_cnt, 1280);
    check_val("bp_seq", seq_err, 0);
    check_val("bp_stall_stable", stall_err, 0);
    check_val("bp_cen_pulses", cen_cnt, 1280);
    check_val("bp_last_addr", last_addr, 14'hABF);

    // Empty range and a single-frame range.
    run_readout(0, 4, 31, 0, 0, got);
    check_val("empty_done_seen", got, 1);
    check_val("empty_cen", cen_cnt, 0);
    check_val("empty_valid", valid_cnt, 0);
    check_val("empty_done_delay", done_cyc - start_cyc, 2);
    run_readout(0, 5, 31, 0, 0, got);
    check_val("one_frame_done_seen", got, 1);
    check_val("one_frame_words", hs_cnt, 64);
    check_val("one_frame_seq", seq_err, 0);
    check_val("one_frame_last_addr", last_addr, 14'h13F);

    // Abort after the 100th handshake, then a fresh start.
    sel = 1'b0;
    clr_mon(24, 31);
    frame_num = 7'd24; cep_num = 7'd31; ready = 1'b1;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    for (int i = 0; i < 2000 && hs_cnt < 100; i++) @(negedge clk);
    check_val("abort_reach_100", hs_cnt, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_valid", if0.out_valid, 0);
    check_val("abort_addr_sel", sel0, 1);
    check_val("abort_busy", busy0, 0);
    check_val("abort_cen", cen0, 1);
    repeat (10) @(negedge clk);
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_hs_frozen", hs_cnt, 100);
    run_readout(0, 5, 31, 0, 0, got);
    check_val("restart_done_seen", got, 1);
    check_val("restart_first_addr", first_addr, 14'h100);
    check_val("restart_words", hs_cnt, 64);

    // Asynchronous reset while a word is held on the stream.
    sel = 1'b0;
    clr_mon(24, 31);
    frame_num = 7'd24; cep_num = 7'd31; ready = 1'b1;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    for (int i = 0; i < 1000 && hs_cnt < 20; i++) @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 20 && !if0.out_valid; i++) @(negedge clk);
    check_val("mid_valid_held", if0.out_valid, 1);
    check_val("mid_busy", busy0, 1);
    check_val("mid_addr_sel", sel0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", if0.out_valid, 0);
    check_val("arst_busy", busy0, 0);
    check_val("arst_addr_sel", sel0, 1);
    check_val("arst_cen", cen0, 1);
    check_val("arst_addr", addr0, 0);
    check_val("arst_data", if0.out_data, 0);
    check_val("arst_frame", if0.out_frame, 0);
    check_val("arst_coef", if0.out_coef, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);

    // Three-cycle read latency instance.
    run_readout(1, 5, 3, 0, 0, got);
    check_val("rl3_done_seen", got, 1);
    check_val("rl3_latency", first_valid_cyc - start_cyc, 6);
    check_val("rl3_words", hs_cnt, 8);
    check_val("rl3_seq", seq_err, 0);
    check_val("rl3_last_addr", last_addr, 14'h107);
    run_readout(1, 6, 1, 1, 0, got);
    check_val("rl3_bp_done_seen", got, 1);
    check_val("rl3_bp_words", hs_cnt, 8);
    check_val("rl3_bp_seq", seq_err, 0);
    check_val("rl3_bp_stall_stable", stall_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
